// File: rtl/dec_serial_tx_pkg.sv
// Shared constants and FSM encoding for the decimator serial output stage.
package dec_serial_tx_pkg;

  localparam int DEC_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/dec_sync_fifo.sv
// Small synchronous FIFO; a push while full (with no pop) is dropped and flagged.
module dec_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pop,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]     level_reg, level_next;
  logic              full;
  logic              wr_en;

  assign full  = (level_reg == FULL_LVL);
  // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;
  assign dout  = mem[rd_ptr_reg];
  assign level = level_reg;

  always_comb begin
    level_next = level_reg;
    if (wr_en && !pop)
      level_next = level_reg + 1'b1;
    else if (!wr_en && pop)
      level_next = level_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
    end
  end

endmodule

// File: rtl/dec_serial_tx.sv
// Buffers decimated words and ships them MSB first on a sclk/sdo/fs serial link.
module dec_serial_tx
  import dec_serial_tx_pkg::*;
#(
  parameter int DATA_W  = DEC_DATA_W,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       sample_in,
  input  logic                    sample_valid,
  output logic                    sclk,
  output logic                    sdo,
  output logic                    fs,
  output logic [$clog2(DEPTH):0]  fifo_level,
  output logic                    overflow
);

  localparam int BW = $clog2(DATA_W);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [BW-1:0] BIT_MSB  = BW'(DATA_W - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV);

  tx_state_e         state_reg, state_next;
  logic [DATA_W-1:0] shreg_reg, shreg_next;
  logic [BW-1:0]     bit_reg, bit_next;
  logic [DW-1:0]     div_reg, div_next;
  logic              sclk_reg, sclk_next;
  logic              sdo_reg, sdo_next;
  logic              fs_reg, fs_next;
  logic              overflow_reg;
  logic              pop;
  logic              drop;
  logic [DATA_W-1:0] head;

  dec_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (sample_valid),
    .din   (sample_in),
    .pop   (pop),
    .dout  (head),
    .level (fifo_level),
    .drop  (drop)
  );

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    bit_next   = bit_reg;
    div_next   = div_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fifo_level != '0)
          state_next = LOAD;
      end
      LOAD: begin
        pop        = 1'b1;
        shreg_next = head;
        bit_next   = BIT_MSB;
        div_next   = '0;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          if (bit_reg == '0) begin
            // Chain straight into the next word so consecutive frames have no gap.
            if (fifo_level != '0) begin
              pop        = 1'b1;
              shreg_next = head;
              bit_next   = BIT_MSB;
            end else begin
              state_next = IDLE;
            end
          end else begin
            shreg_next = {shreg_reg[DATA_W-2:0], 1'b0};
            bit_next   = bit_reg - 1'b1;
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Outputs are derived from the next state so the registered pins line up with it.
    sclk_next = 1'b0;
    sdo_next  = 1'b0;
    fs_next   = 1'b0;
    if (state_next == SHIFT) begin
      sdo_next  = shreg_next[DATA_W-1];
      sclk_next = (div_next >= DIV_HALF);
      fs_next   = (bit_next == BIT_MSB);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      shreg_reg    <= '0;
      bit_reg      <= '0;
      div_reg      <= '0;
      sclk_reg     <= 1'b0;
      sdo_reg      <= 1'b0;
      fs_reg       <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shreg_reg    <= shreg_next;
      bit_reg      <= bit_next;
      div_reg      <= div_next;
      sclk_reg     <= sclk_next;
      sdo_reg      <= sdo_next;
      fs_reg       <= fs_next;
      overflow_reg <= overflow_reg | drop;
    end
  end

  assign sclk     = sclk_reg;
  assign sdo      = sdo_reg;
  assign fs       = fs_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_dec_serial_tx.sv
// Scoreboard bench for dec_serial_tx: three instances at CLK_DIV 2, 1 and 5 share clock and data bus.
module tb_dec_serial_tx;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;
  localparam int NI     = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] sin = '0;
  logic [NI-1:0]     sv  = '0;
  logic [NI-1:0]     acc = '0;
  logic              sclk_w [NI];
  logic              sdo_w  [NI];
  logic              fs_w   [NI];
  logic              ovf_w  [NI];
  logic [2:0]        lvl_w  [NI];

  logic [DATA_W-1:0] exp_q [NI][$];
  logic [DATA_W-1:0] mon_exp;
  int                n_checks = 0;
  int                n_pass   = 0;
  int                cyc      = 0;
  int                bitn      [NI];
  int                fs_cnt    [NI];
  int                err       [NI];
  int                last_rise [NI];
  logic              prev      [NI];
  logic              cur_bit   [NI];
  logic [DATA_W-1:0] word      [NI];

  always #5 clk = ~clk;

  function automatic int cd_of(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 5;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    dec_serial_tx #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .CLK_DIV ((gi == 0) ? 2 : (gi == 1) ? 1 : 5)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_in    (sin),
      .sample_valid (sv[gi]),
      .sclk         (sclk_w[gi]),
      .sdo          (sdo_w[gi]),
      .fs           (fs_w[gi]),
      .fifo_level   (lvl_w[gi]),
      .overflow     (ovf_w[gi])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Receiver model: samples sdo on each sclk rise, scores words against the queue.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        exp_q[i].delete();
        bitn[i]   = 0;
        fs_cnt[i] = 0;
        err[i]    = 0;
        prev[i]   = 1'b0;
      end else begin
        if (sv[i] && acc[i])
          exp_q[i].push_back(sin);
        if (fs_w[i])
          fs_cnt[i]++;
        if (sclk_w[i] && !prev[i]) begin
          if (fs_w[i]) begin
            if (bitn[i] != 0) err[i]++;
            bitn[i] = 0;
          end else if (bitn[i] == 0) begin
            err[i]++;
          end else if (cyc - last_rise[i] != 2 * cd_of(i)) begin
            err[i]++;
          end
          last_rise[i] = cyc;
          cur_bit[i]   = sdo_w[i];
          word[i]      = {word[i][DATA_W-2:0], sdo_w[i]};
          bitn[i]++;
          if (bitn[i] == DATA_W) begin
            $display("rx[%0d] word=%h", i, word[i]);
            chk("sb_pending", 32'(exp_q[i].size() != 0), 1);
            if (exp_q[i].size() != 0) begin
              mon_exp = exp_q[i].pop_front();
              chk("rx_word", 32'(word[i]), 32'(mon_exp));
            end
            chk("fs_width", fs_cnt[i], 2 * cd_of(i));
            chk("sclk_sdo_timing", err[i], 0);
            fs_cnt[i] = 0;
            err[i]    = 0;
            bitn[i]   = 0;
          end
        end else if (sclk_w[i] && (sdo_w[i] != cur_bit[i])) begin
          err[i]++;
        end
        prev[i] = sclk_w[i];
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [NI-1:0] m, input logic [DATA_W-1:0] w, input logic a);
    sin = w;
    sv  = m;
    acc = a ? m : '0;
    step();
    sv  = '0;
    acc = '0;
  endtask

  task automatic drain(input int max_cyc);
    int k;
    k = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && k < max_cyc) begin
      step();
      k++;
    end
    chk("drain_done", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    step(12);
    for (int i = 0; i < NI; i++) begin
      chk("idle_pins", 32'({sclk_w[i], sdo_w[i], fs_w[i]}), 0);
      chk("idle_level", 32'(lvl_w[i]), 0);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_sclk"}, 32'(sclk_w[0]), 0);
    chk({tag, "_sdo"}, 32'(sdo_w[0]), 0);
    chk({tag, "_fs"}, 32'(fs_w[0]), 0);
    chk({tag, "_level"}, 32'(lvl_w[0]), 0);
    chk({tag, "_ovf"}, 32'(ovf_w[0]), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    rst_n = 1'b0;
    step(2);
    check_reset_state("reset");
    rst_n = 1'b1;
    step();

    // Single word, 3-edge latency
    pulse(3'b001, 16'hA5C3, 1'b1);
    chk("lat_e0_fs", 32'(fs_w[0]), 0);
    chk("lat_e0_lvl", 32'(lvl_w[0]), 1);
    step();
    chk("lat_e1_fs", 32'(fs_w[0]), 0);
    step();
    chk("lat_e2_fs", 32'(fs_w[0]), 1);
    chk("lat_e2_sdo", 32'(sdo_w[0]), 1);
    chk("lat_e2_lvl", 32'(lvl_w[0]), 0);
    drain(200);

    // Back-to-back frames
    pulse(3'b001, 16'h0001, 1'b1);
    chk("b2b_lvl_a", 32'(lvl_w[0]), 1);
    pulse(3'b001, 16'h8000, 1'b1);
    chk("b2b_lvl_b", 32'(lvl_w[0]), 2);
    pulse(3'b001, 16'hFFFF, 1'b1);
    chk("b2b_lvl_c", 32'(lvl_w[0]), 2);
    chk("b2b_fs_o0", 32'(fs_w[0]), 1);
    step(63);
    chk("b2b_fs_o63", 32'(fs_w[0]), 0);
    chk("b2b_sclk_o63", 32'(sclk_w[0]), 1);
    step();
    chk("b2b_fs_o64", 32'(fs_w[0]), 1);
    step(64);
    chk("b2b_fs_o128", 32'(fs_w[0]), 1);
    step(64);
    chk("b2b_idle_o192", 32'({sclk_w[0], fs_w[0]}), 0);
    drain(100);

    // Overflow: sixth strobe is dropped
    for (int k = 0; k < 6; k++) begin
      pulse(3'b001, 16'h1000 + 16'(k), (k < 5));
      if (k == 4) begin
        chk("ovf_lvl_full", 32'(lvl_w[0]), 4);
        chk("ovf_before", 32'(ovf_w[0]), 0);
      end
    end
    chk("ovf_lvl_after", 32'(lvl_w[0]), 4);
    chk("ovf_set", 32'(ovf_w[0]), 1);
    drain(600);
    chk("ovf_sticky", 32'(ovf_w[0]), 1);
    rst_n = 1'b0;
    step();
    check_reset_state("ovf_rst");
    rst_n = 1'b1;
    step();

    // Full FIFO with a push on the end-of-frame pop edge
    for (int k = 0; k < 5; k++)
      pulse(3'b001, 16'h2000 + 16'(k), 1'b1);
    chk("fpp_lvl_pre", 32'(lvl_w[0]), 4);
    step(61);
    chk("fpp_lvl_wait", 32'(lvl_w[0]), 4);
    pulse(3'b001, 16'h2ABC, 1'b1);
    chk("fpp_lvl_post", 32'(lvl_w[0]), 4);
    chk("fpp_ovf", 32'(ovf_w[0]), 0);
    chk("fpp_fs", 32'(fs_w[0]), 1);
    drain(600);
    chk("fpp_ovf_end", 32'(ovf_w[0]), 0);

    // Mid-frame reset during bit 7
    pulse(3'b001, 16'h1234, 1'b1);
    step(2);
    step(33);
    rst_n = 1'b0;
    step();
    check_reset_state("mid_rst");
    rst_n = 1'b1;
    pulse(3'b001, 16'hA5C3, 1'b1);
    chk("rst_lat_e0_fs", 32'(fs_w[0]), 0);
    step();
    chk("rst_lat_e1_fs", 32'(fs_w[0]), 0);
    step();
    chk("rst_lat_e2_fs", 32'(fs_w[0]), 1);
    chk("rst_lat_e2_sdo", 32'(sdo_w[0]), 1);
    drain(200);

    // Divider sweep on the CLK_DIV=1 and CLK_DIV=5 instances
    pulse(3'b110, 16'h5555, 1'b1);
    chk("div_e0_fs1", 32'(fs_w[1]), 0);
    step();
    chk("div_e1_fs1", 32'(fs_w[1]), 0);
    step();
    chk("div_e2_fs1", 32'(fs_w[1]), 1);
    chk("div_e2_fs5", 32'(fs_w[2]), 1);
    chk("div_e2_sdo1", 32'(sdo_w[1]), 0);
    chk("div_e2_sclk5", 32'(sclk_w[2]), 0);
    step(5);
    chk("div_o5_sclk5", 32'(sclk_w[2]), 1);
    drain(400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
